// File: rtl/sha256_pkg.sv
// Shared SHA-256 helpers: round functions, schedule sigmas, block state encoding.
// The K constant table exists only when SHA256_SCHED_KOUT_EN is defined.
package sha256_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Message-schedule sigmas: two rotates and a logical shift each
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

`ifdef SHA256_SCHED_KOUT_EN
  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: expands one 512-bit block into W0..W63 via a 16-word window.
// Define SHA256_SCHED_KOUT_EN to add the k_out round-constant output.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
`ifdef SHA256_SCHED_KOUT_EN
  output logic [31:0]  k_out,
`endif
  output logic         busy
);

  logic [0:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic        run;

  assign run = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    if (!run) begin
      if (blk_valid) begin
        for (int i = 0; i < 16; i++) win_d[i] = blk_data[511-32*i -: 32];
        idx_d   = 6'd0;
        state_d = ST_RUN;
      end
    end else if (w_ready) begin
      // Slide the window; the new tail word is W[t+16] for the W[t] just consumed
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
      if (idx_q == 6'd63) begin
        idx_d   = 6'd0;
        state_d = ST_IDLE;
      end else begin
        idx_d = idx_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 6'd0;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign blk_ready = !run;
  assign busy      = run;
  assign w_valid   = run;
  assign w_idx     = idx_q;
  assign w_out     = run ? win_q[0] : 32'd0;

`ifdef SHA256_SCHED_KOUT_EN
  assign k_out = run ? K_TABLE[idx_q] : 32'd0;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: full-schedule reference model plus directed scenarios.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         busy;
`ifdef SHA256_SCHED_KOUT_EN
  logic [31:0]  k_out;
`endif

  always #5 clk = ~clk;

  sha256_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .w_idx     (w_idx),
`ifdef SHA256_SCHED_KOUT_EN
    .k_out     (k_out),
`endif
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: whole 64-word schedule from the textbook recurrence
  logic [31:0] cur_exp [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function void load_sched(input logic [511:0] b);
    for (int t = 0; t < 16; t++) cur_exp[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      cur_exp[t] = s1(cur_exp[t-2]) + cur_exp[t-7] + s0(cur_exp[t-15]) + cur_exp[t-16];
  endfunction

  bit          m_run       = 1'b0;
  int          exp_idx     = 0;
  int          blocks_done = 0;
  bit          stall_prev  = 1'b0;
  logic [31:0] prev_out    = 32'd0;
  bit          mon_en      = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_w_out",   w_out,            32'd0);
        chk("rst_w_idx",   {26'd0, w_idx},   32'd0);
`ifdef SHA256_SCHED_KOUT_EN
        chk("rst_k_out",   k_out,            32'd0);
`endif
        m_run      = 1'b0;
        exp_idx    = 0;
        stall_prev = 1'b0;
      end else begin
        chk("blk_ready", {31'd0, blk_ready}, {31'd0, !m_run});
        chk("w_valid",   {31'd0, w_valid},   {31'd0, m_run});
        chk("busy",      {31'd0, busy},      {31'd0, m_run});
        if (m_run) begin
          chk("w_idx", {26'd0, w_idx}, exp_idx);
          chk("w_out", w_out, cur_exp[exp_idx]);
          if (stall_prev) chk("w_out_stall_hold", w_out, prev_out);
`ifdef SHA256_SCHED_KOUT_EN
          if (exp_idx == 0)  chk("k_out_0",  k_out, 32'h428A2F98);
          if (exp_idx == 63) chk("k_out_63", k_out, 32'hC67178F2);
`endif
        end else begin
          chk("idle_w_idx", {26'd0, w_idx}, 32'd0);
`ifdef SHA256_SCHED_KOUT_EN
          chk("idle_k_out", k_out, 32'd0);
`endif
        end
        stall_prev = m_run && !w_ready;
        prev_out   = w_out;
        if (m_run) begin
          if (w_ready) begin
            if (exp_idx == 63) begin
              m_run   = 1'b0;
              exp_idx = 0;
              blocks_done++;
            end else begin
              exp_idx++;
            end
          end
        end else if (blk_valid) begin
          load_sched(blk_data);
          m_run   = 1'b1;
          exp_idx = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int rmode);
    w_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // Offer block d; with hold set, keep blk_valid high and switch data to d2 during RUN
  task automatic run_block(input logic [511:0] d, input logic [511:0] d2,
                           input bit hold, input int rmode);
    int target;
    int cyc;
    target    = blocks_done + (hold ? 2 : 1);
    blk_data  = d;
    blk_valid = 1'b1;
    set_ready(rmode);
    tick();
    if (hold) blk_data = d2;
    else      blk_valid = 1'b0;
    cyc = 0;
    while (blocks_done < target && cyc < 2000) begin
      set_ready(rmode);
      tick();
      cyc++;
      if (hold && blocks_done == target - 1 && blk_valid) begin
        tick();
        cyc++;
        blk_valid = 1'b0;
      end
    end
    chk("block_complete_in_budget", {31'd0, blocks_done >= target}, 32'd1);
    w_ready = 1'b0;
    tick();
  endtask

  localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};

  logic [511:0] other;
  logic [511:0] rnd;
  int           cyc;

  initial begin
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    w_ready   = 1'b0;

    // Pin the reference model against hand-derived "abc" schedule words
    load_sched(ABC);
    chk("model_W0",  cur_exp[0],  32'h61626380);
    chk("model_W15", cur_exp[15], 32'h00000018);
    chk("model_W16", cur_exp[16], 32'h61626380);
    chk("model_W17", cur_exp[17], 32'h000F0000);

    mon_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // "abc" block, w_ready held high
    run_block(ABC, '0, 1'b0, 0);
    chk("abc_blocks_done", blocks_done, 32'd1);

    // Same block, random w_ready back-pressure
    run_block(ABC, '0, 1'b0, 1);

    // blk_valid held through RUN with different data
    for (int i = 0; i < 16; i++) other[511-32*i -: 32] = 32'h01234567 * (i + 1) ^ 32'hA5A5_0000;
    run_block(ABC, other, 1'b1, 0);

    // Reset in the middle of a block at w_idx = 30
    blk_data  = other;
    blk_valid = 1'b1;
    w_ready   = 1'b1;
    tick();
    blk_valid = 1'b0;
    cyc = 0;
    while (!(m_run && exp_idx == 30) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("reached_idx30", {31'd0, m_run && exp_idx == 30}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_w_valid", {31'd0, w_valid}, 32'd0);
    chk("async_rst_w_idx",   {26'd0, w_idx},   32'd0);
    tick();
    tick();
    rst_n   = 1'b1;
    w_ready = 1'b0;
    tick();
    run_block(ABC, '0, 1'b0, 0);

    // Random blocks, accepted as soon as the block returns to IDLE
    for (int b = 0; b < 60; b++) begin
      for (int i = 0; i < 16; i++) rnd[511-32*i -: 32] = $urandom;
      run_block(rnd, '0, 1'b0, (b % 3 == 2) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
